// File: rtl/xilinx_fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
package xilinx_fifo_pkg;

  typedef enum logic {FIFO_STD, FIFO_FWFT} fifo_mode_e;

  localparam int MAX_WIDTH = 1024;
  localparam int MAX_PBITS = MAX_WIDTH / 8;

  function automatic int parity_bits(input int width);
    return (width + 7) / 8;
  endfunction

  // Callers zero-extend their word; unused upper bytes yield 0.
  function automatic logic [MAX_PBITS-1:0] byte_parity(input logic [MAX_WIDTH-1:0] data);
    logic [MAX_PBITS-1:0] p;
    p = '0;
    for (int i = 0; i < MAX_PBITS; i++) p[i] = ^data[i*8 +: 8];
    return p;
  endfunction

endpackage

// File: rtl/xilinx_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array itself is never reset so it maps onto block RAM.
module xilinx_ram_sdp #(
  parameter int WIDTH  = 36,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (re) q <= mem[raddr];
  end

endmodule

// File: rtl/xilinx_fifo_sync.sv
// Single-clock FIFO with occupancy count, standard/FWFT read modes and error flags.
// Optional per-byte parity storage/check under XILINX_FIFO_SYNC_PARITY_EN.
module xilinx_fifo_sync
  import xilinx_fifo_pkg::*;
#(
  parameter int    DATA_WIDTH              = 36,
  parameter int    DEPTH_LOG2              = 10,
  parameter int    ALMOST_EMPTY_OFFSET     = 128,
  parameter int    ALMOST_FULL_OFFSET      = 128,
  parameter string FIRST_WORD_FALL_THROUGH = "FALSE"
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WREN,
  input  logic [DATA_WIDTH-1:0] DI,
  input  logic                  INJECTPERR,
  input  logic                  RDEN,
  output logic [DATA_WIDTH-1:0] DO,
  output logic                  EMPTY,
  output logic                  FULL,
  output logic                  ALMOSTEMPTY,
  output logic                  ALMOSTFULL,
  output logic [DEPTH_LOG2:0]   DATACOUNT,
  output logic                  WRERR,
  output logic                  RDERR,
  output logic                  PARERR
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
`ifdef XILINX_FIFO_SYNC_PARITY_EN
  localparam int PW    = parity_bits(DATA_WIDTH);
`else
  localparam int PW    = 0;
`endif
  localparam int RW    = DATA_WIDTH + PW;
  localparam fifo_mode_e MODE = (FIRST_WORD_FALL_THROUGH == "TRUE") ? FIFO_FWFT : FIFO_STD;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH    = CW'(DEPTH - ALMOST_FULL_OFFSET);
  localparam logic [CW-1:0] AE_TH    = CW'(ALMOST_EMPTY_OFFSET);

  if (DATA_WIDTH < 1 || DATA_WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("xilinx_fifo_sync: DATA_WIDTH out of range");
  end
  if (DEPTH_LOG2 < 2 || DEPTH_LOG2 > 16) begin : g_bad_depth
    $error("xilinx_fifo_sync: DEPTH_LOG2 out of range");
  end
  if (ALMOST_EMPTY_OFFSET >= DEPTH || ALMOST_FULL_OFFSET >= DEPTH) begin : g_bad_offset
    $error("xilinx_fifo_sync: almost offsets must be below DEPTH");
  end
  if (FIRST_WORD_FALL_THROUGH != "TRUE" && FIRST_WORD_FALL_THROUGH != "FALSE") begin : g_bad_mode
    $error("xilinx_fifo_sync: FIRST_WORD_FALL_THROUGH must be TRUE or FALSE");
  end

  logic [DEPTH_LOG2-1:0] wptr, rptr;
  logic [CW-1:0]         count_nxt, ram_words;
  logic                  wr_acc, rd_acc, re, fetch, out_take;
  logic                  qvalid, ovalid, qvalid_nxt, ovalid_nxt;
  logic [RW-1:0]         wdata, ram_q, out_word;

  // FWFT: RAM read register acts as a middle stage, out_word is the visible head.
  always_comb begin
    wr_acc     = WREN && !FULL;
    rd_acc     = RDEN && !EMPTY;
    count_nxt  = DATACOUNT + CW'(wr_acc) - CW'(rd_acc);
    ram_words  = DATACOUNT - CW'(ovalid) - CW'(qvalid);
    out_take   = 1'b0;
    fetch      = 1'b0;
    qvalid_nxt = 1'b0;
    ovalid_nxt = 1'b0;
    re         = rd_acc;
    if (MODE == FIFO_FWFT) begin
      out_take   = qvalid && (!ovalid || rd_acc);
      fetch      = (ram_words != '0) && (!qvalid || out_take);
      qvalid_nxt = fetch || (qvalid && !out_take);
      ovalid_nxt = out_take || (ovalid && !rd_acc);
      re         = fetch;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr        <= '0;
      rptr        <= '0;
      DATACOUNT   <= '0;
      FULL        <= 1'b0;
      EMPTY       <= 1'b1;
      ALMOSTFULL  <= 1'b0;
      ALMOSTEMPTY <= 1'b1;
      WRERR       <= 1'b0;
      RDERR       <= 1'b0;
      qvalid      <= 1'b0;
      ovalid      <= 1'b0;
      out_word    <= '0;
    end else begin
      wptr        <= wptr + DEPTH_LOG2'(wr_acc);
      rptr        <= rptr + DEPTH_LOG2'(re);
      DATACOUNT   <= count_nxt;
      FULL        <= (count_nxt == FULL_CNT);
      ALMOSTFULL  <= (count_nxt >= AF_TH);
      ALMOSTEMPTY <= (count_nxt <= AE_TH);
      EMPTY       <= (MODE == FIFO_FWFT) ? !ovalid_nxt : (count_nxt == '0);
      WRERR       <= WREN && FULL;
      RDERR       <= RDEN && EMPTY;
      qvalid      <= qvalid_nxt;
      ovalid      <= ovalid_nxt;
      if (out_take) out_word <= ram_q;
    end
  end

  assign DO = (MODE == FIFO_FWFT) ? out_word[DATA_WIDTH-1:0] : ram_q[DATA_WIDTH-1:0];

`ifdef XILINX_FIFO_SYNC_PARITY_EN
  logic [MAX_PBITS-1:0] wpar, dpar;
  logic [RW-1:0]        shown;

  // Error follows whichever word is currently presented on DO.
  always_comb begin
    wpar   = byte_parity(MAX_WIDTH'(DI));
    wdata  = {wpar[PW-1:0] ^ {PW{INJECTPERR}}, DI};
    shown  = (MODE == FIFO_FWFT) ? out_word : ram_q;
    dpar   = byte_parity(MAX_WIDTH'(shown[DATA_WIDTH-1:0]));
    PARERR = (dpar[PW-1:0] != shown[RW-1:DATA_WIDTH]) && ((MODE != FIFO_FWFT) || ovalid);
  end
`else
  logic unused_inj;
  assign unused_inj = INJECTPERR;
  assign wdata      = DI;
  assign PARERR     = 1'b0;
`endif

  xilinx_ram_sdp #(.WIDTH(RW), .ADDR_W(DEPTH_LOG2)) u_ram (
    .clk   (CLK),
    .rst_n (RST_N),
    .we    (wr_acc),
    .waddr (wptr),
    .wdata (wdata),
    .re    (re),
    .raddr (rptr),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_xilinx_fifo_sync.sv
// Bench: standard and FWFT instances driven against a queue-based reference model.
module tb_xilinx_fifo_sync;
  localparam int DW = 32, AW = 4, DEPTH = 16, AEO = 2, AFO = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int en = 0;
  always @(posedge clk) en <= en + 1;

  logic          s_wr = 0, s_rd = 0, s_inj = 0, f_wr = 0, f_rd = 0, f_inj = 0;
  logic [DW-1:0] s_di = '0, f_di = '0, s_do, f_do;
  logic          s_empty, s_full, s_ae, s_af, s_wrerr, s_rderr, s_parerr;
  logic          f_empty, f_full, f_ae, f_af, f_wrerr, f_rderr, f_parerr;
  logic [AW:0]   s_cnt, f_cnt;

  xilinx_fifo_sync #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW), .ALMOST_EMPTY_OFFSET(AEO),
    .ALMOST_FULL_OFFSET(AFO), .FIRST_WORD_FALL_THROUGH("FALSE")) u_std (
    .CLK(clk), .RST_N(rst_n), .WREN(s_wr), .DI(s_di), .INJECTPERR(s_inj), .RDEN(s_rd),
    .DO(s_do), .EMPTY(s_empty), .FULL(s_full), .ALMOSTEMPTY(s_ae), .ALMOSTFULL(s_af),
    .DATACOUNT(s_cnt), .WRERR(s_wrerr), .RDERR(s_rderr), .PARERR(s_parerr));

  xilinx_fifo_sync #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW), .ALMOST_EMPTY_OFFSET(AEO),
    .ALMOST_FULL_OFFSET(AFO), .FIRST_WORD_FALL_THROUGH("TRUE")) u_fwft (
    .CLK(clk), .RST_N(rst_n), .WREN(f_wr), .DI(f_di), .INJECTPERR(f_inj), .RDEN(f_rd),
    .DO(f_do), .EMPTY(f_empty), .FULL(f_full), .ALMOSTEMPTY(f_ae), .ALMOSTFULL(f_af),
    .DATACOUNT(f_cnt), .WRERR(f_wrerr), .RDERR(f_rderr), .PARERR(f_parerr));

  typedef struct {logic [DW-1:0] d; bit inj; int t;} ent_t;
  ent_t sq[$], fq[$];
  logic [DW-1:0] s_do_e = '0;
  bit s_par_e = 0, s_we_e = 0, s_re_e = 0, f_we_e = 0, f_re_e = 0;
  int total = 0, bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // FWFT head becomes visible two edges after the edge that wrote it.
  function automatic bit f_hidden();
    if (fq.size() == 0) return 1'b1;
    return (fq[0].t + 2 > en);
  endfunction

  function automatic bit par_on(input bit b);
`ifdef XILINX_FIFO_SYNC_PARITY_EN
    return b;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all();
    chk("s_cnt", 32'(s_cnt), sq.size());
    chk("s_full", 32'(s_full), 32'(sq.size() == DEPTH));
    chk("s_empty", 32'(s_empty), 32'(sq.size() == 0));
    chk("s_af", 32'(s_af), 32'(sq.size() >= DEPTH - AFO));
    chk("s_ae", 32'(s_ae), 32'(sq.size() <= AEO));
    chk("s_do", s_do, s_do_e);
    chk("s_wrerr", 32'(s_wrerr), 32'(s_we_e));
    chk("s_rderr", 32'(s_rderr), 32'(s_re_e));
    chk("s_parerr", 32'(s_parerr), 32'(par_on(s_par_e)));
    chk("f_cnt", 32'(f_cnt), fq.size());
    chk("f_full", 32'(f_full), 32'(fq.size() == DEPTH));
    chk("f_af", 32'(f_af), 32'(fq.size() >= DEPTH - AFO));
    chk("f_ae", 32'(f_ae), 32'(fq.size() <= AEO));
    chk("f_empty", 32'(f_empty), 32'(f_hidden()));
    chk("f_wrerr", 32'(f_wrerr), 32'(f_we_e));
    chk("f_rderr", 32'(f_rderr), 32'(f_re_e));
    if (!f_hidden()) begin
      chk("f_do", f_do, fq[0].d);
      chk("f_parerr", 32'(f_parerr), 32'(par_on(fq[0].inj)));
    end else chk("f_parerr", 32'(f_parerr), 32'd0);
  endtask

  task automatic tick();
    bit sfull, sempty, ffull, fempty;
    ent_t e;
    sfull  = (sq.size() == DEPTH);
    sempty = (sq.size() == 0);
    ffull  = (fq.size() == DEPTH);
    fempty = f_hidden();
    @(posedge clk); #1;
    s_we_e = s_wr && sfull;
    s_re_e = s_rd && sempty;
    if (s_rd && !sempty) begin e = sq.pop_front(); s_do_e = e.d; s_par_e = e.inj; end
    if (s_wr && !sfull) sq.push_back('{s_di, s_inj, en});
    f_we_e = f_wr && ffull;
    f_re_e = f_rd && fempty;
    if (f_rd && !fempty) e = fq.pop_front();
    if (f_wr && !ffull) fq.push_back('{f_di, f_inj, en});
    check_all();
  endtask

  task automatic s_op(input bit w, input bit r, input logic [DW-1:0] d, input bit inj);
    s_wr = w; s_rd = r; s_di = d; s_inj = inj; f_wr = 0; f_rd = 0; f_di = '0; f_inj = 0;
    tick();
  endtask

  task automatic f_op(input bit w, input bit r, input logic [DW-1:0] d, input bit inj);
    f_wr = w; f_rd = r; f_di = d; f_inj = inj; s_wr = 0; s_rd = 0; s_di = '0; s_inj = 0;
    tick();
  endtask

  // Drops reset between edges, so only an asynchronous clear is observed.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_s_cnt", 32'(s_cnt), 0);   chk("rst_f_cnt", 32'(f_cnt), 0);
    chk("rst_s_empty", 32'(s_empty), 1); chk("rst_f_empty", 32'(f_empty), 1);
    chk("rst_s_ae", 32'(s_ae), 1);     chk("rst_f_ae", 32'(f_ae), 1);
    chk("rst_s_full", 32'(s_full), 0); chk("rst_f_full", 32'(f_full), 0);
    chk("rst_s_af", 32'(s_af), 0);     chk("rst_f_af", 32'(f_af), 0);
    chk("rst_s_do", s_do, 0);          chk("rst_f_do", f_do, 0);
    chk("rst_s_err", {29'd0, s_wrerr, s_rderr, s_parerr}, 0);
    chk("rst_f_err", {29'd0, f_wrerr, f_rderr, f_parerr}, 0);
    sq.delete(); fq.delete();
    s_do_e = '0; s_par_e = 0; s_we_e = 0; s_re_e = 0; f_we_e = 0; f_re_e = 0;
    s_wr = 0; s_rd = 0; s_inj = 0; f_wr = 0; f_rd = 0; f_inj = 0;
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // standard mode: empty read, then write+read on empty
    s_op(0, 1, '0, 0);
    s_op(1, 1, 32'hA5, 0);
    s_op(0, 1, '0, 0);
    chk("s_do_a5", s_do, 32'hA5);
    for (int i = 1; i <= 17; i++) s_op(1, 0, 32'(i), 0);
    chk("s_full_16", 32'(s_full), 1);
    s_op(1, 1, 32'h99, 0);
    chk("s_full_rw_do", s_do, 32'h1);
    for (int i = 0; i < 16; i++) s_op(0, 1, '0, 0);

    // parity neighbours in standard mode
    s_op(1, 0, 32'h11111111, 0);
    s_op(1, 0, 32'hDEADBEEF, 1);
    s_op(1, 0, 32'h22222222, 0);
    for (int i = 0; i < 4; i++) s_op(0, 1, '0, 0);

    // FWFT: first-word latency
    f_op(1, 0, 32'h3C, 0);
    f_op(0, 0, '0, 0);
    f_op(0, 0, '0, 0);
    chk("f_do_3c", f_do, 32'h3C);
    f_op(0, 1, '0, 0);

    // FWFT: sustained write+pop across two pointer wraps
    for (int i = 0; i < 5; i++) f_op(1, 0, 32'(100 + i), 0);
    f_op(0, 0, '0, 0); f_op(0, 0, '0, 0);
    for (int i = 0; i < 40; i++) begin
      f_op(1, 1, 32'(200 + i), 0);
      chk("f_stream_cnt", 32'(f_cnt), 5);
    end
    for (int i = 0; i < 20; i++) f_op(1, 0, 32'(300 + i), 0);
    f_op(1, 1, 32'h77, 0);
    for (int i = 0; i < 20; i++) f_op(0, 1, '0, 0);

    f_op(1, 0, 32'h11111111, 0);
    f_op(1, 0, 32'hDEADBEEF, 1);
    f_op(1, 0, 32'h22222222, 0);
    for (int i = 0; i < 6; i++) f_op(0, (i % 2) == 1, '0, 0);
    for (int i = 0; i < 3; i++) f_op(0, 1, '0, 0);

    // random traffic on both, write-heavy then read-heavy phases
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 100; i++) begin
        int pw;
        pw = (ph % 2 == 0) ? 70 : 30;
        s_wr = ($urandom_range(0, 99) < pw); s_rd = ($urandom_range(0, 99) >= pw);
        s_di = $urandom; s_inj = ($urandom_range(0, 7) == 0);
        f_wr = ($urandom_range(0, 99) < pw); f_rd = ($urandom_range(0, 99) >= pw);
        f_di = $urandom; f_inj = ($urandom_range(0, 7) == 0);
        tick();
      end
    end

    // drain, refill to 9 and reset mid-burst
    for (int i = 0; i < 20; i++) begin
      s_wr = 0; s_rd = 1; f_wr = 0; f_rd = 1; s_inj = 0; f_inj = 0;
      tick();
    end
    for (int i = 0; i < 9; i++) begin
      s_wr = 1; s_rd = 0; s_di = 32'(400 + i); f_wr = 1; f_rd = 0; f_di = 32'(500 + i);
      tick();
    end
    chk("s_cnt_9", 32'(s_cnt), 9);
    chk("f_cnt_9", 32'(f_cnt), 9);
    do_reset();

    s_op(1, 0, 32'h5A5A, 0);
    s_op(0, 1, '0, 0);
    chk("s_post_rst", s_do, 32'h5A5A);
    f_op(1, 0, 32'hC3C3, 0);
    f_op(0, 0, '0, 0);
    f_op(0, 0, '0, 0);
    chk("f_post_rst", f_do, 32'hC3C3);
    f_op(0, 1, '0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
